// File: rtl/aes_uart_pkg.sv
// Shared constants and types for the AES receive-side sequencer.
package aes_uart_pkg;

  localparam logic [7:0] CMD_KEY  = 8'h4B;
  localparam logic [7:0] CMD_DATA = 8'h44;

  localparam int BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CMD     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_NOKEY   = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  typedef enum logic {
    TGT_KEY  = 1'b0,
    TGT_DATA = 1'b1
  } target_e;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter; expired asserts once Cycles-1 idle clocks have elapsed.
module byte_timeout #(
  parameter int unsigned Cycles = 2000000,
  parameter int unsigned Bits   = 21
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [Bits-1:0] LAST = Bits'(Cycles - 1);

  logic [Bits-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a missed clear can never wrap into a false restart.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/aes_rx_sequencer.sv
// Receive-side sequencer: parses a command byte, assembles 16 payload bytes
// into a key or data block, and hands data blocks to the AES core.
module aes_rx_sequencer
  import aes_uart_pkg::*;
#(
  parameter int unsigned ClkFreq       = 100000000,
  parameter int unsigned TimeoutCycles = ClkFreq / 50,
  parameter int unsigned TimeoutBits   = 21
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   ByteIn,
  input  logic         ByteReady,
  output logic         ReadEn,
  output logic [127:0] KeyOut,
  output logic         KeyValid,
  output logic         KeyLoaded,
  output logic [127:0] BlockOut,
  output logic         BlockValid,
  input  logic         BlockReady,
  output logic         ErrFlag,
  output logic [1:0]   ErrCode
);

  localparam logic [3:0] LAST_BYTE = 4'(BLOCK_BYTES - 1);

  state_e       state_q, state_d;
  target_e      target_q, target_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [127:0] shreg_q, shreg_d;
  logic [127:0] key_q, key_d;
  logic         key_valid_q, key_valid_d;
  logic         key_loaded_q, key_loaded_d;
  logic [127:0] block_q, block_d;
  logic         block_valid_q, block_valid_d;
  logic         read_en_q, read_en_d;
  logic         err_flag_q, err_flag_d;
  err_code_e    err_code_q, err_code_d;

  logic         timeout_expired;
  logic [127:0] assembled;

  assign assembled = {shreg_q[119:0], ByteIn};

  // Held at zero outside LOAD; a byte strobe restarts the idle window.
  byte_timeout #(
    .Cycles(TimeoutCycles),
    .Bits  (TimeoutBits)
  ) u_timeout (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr_i    ((state_q != ST_LOAD) || ByteReady),
    .en_i     (state_q == ST_LOAD),
    .expired_o(timeout_expired)
  );

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    byte_cnt_d    = byte_cnt_q;
    shreg_d       = shreg_q;
    key_d         = key_q;
    key_valid_d   = 1'b0;
    key_loaded_d  = key_loaded_q;
    block_d       = block_q;
    block_valid_d = block_valid_q;
    err_flag_d    = err_flag_q;
    err_code_d    = err_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ByteReady) begin
          if ((ByteIn == CMD_KEY) || (ByteIn == CMD_DATA)) begin
            state_d    = ST_LOAD;
            target_d   = (ByteIn == CMD_KEY) ? TGT_KEY : TGT_DATA;
            byte_cnt_d = '0;
            err_flag_d = 1'b0;
            err_code_d = ERR_NONE;
          end else begin
            err_flag_d = 1'b1;
            err_code_d = ERR_CMD;
          end
        end
      end

      ST_LOAD: begin
        // A strobe coinciding with expiry wins: the byte is taken.
        if (ByteReady) begin
          shreg_d    = assembled;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_IDLE;
            if (target_q == TGT_KEY) begin
              key_d        = assembled;
              key_valid_d  = 1'b1;
              key_loaded_d = 1'b1;
            end else if (key_loaded_q) begin
              block_d       = assembled;
              block_valid_d = 1'b1;
              state_d       = ST_HOLD;
            end else begin
              err_flag_d = 1'b1;
              err_code_d = ERR_NOKEY;
            end
          end
        end else if (timeout_expired) begin
          state_d    = ST_IDLE;
          err_flag_d = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      ST_HOLD: begin
        if (block_valid_q && BlockReady) begin
          block_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    read_en_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      target_q      <= TGT_KEY;
      byte_cnt_q    <= '0;
      shreg_q       <= '0;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      key_loaded_q  <= 1'b0;
      block_q       <= '0;
      block_valid_q <= 1'b0;
      read_en_q     <= 1'b1;
      err_flag_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      byte_cnt_q    <= byte_cnt_d;
      shreg_q       <= shreg_d;
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      key_loaded_q  <= key_loaded_d;
      block_q       <= block_d;
      block_valid_q <= block_valid_d;
      read_en_q     <= read_en_d;
      err_flag_q    <= err_flag_d;
      err_code_q    <= err_code_d;
    end
  end

  assign ReadEn     = read_en_q;
  assign KeyOut     = key_q;
  assign KeyValid   = key_valid_q;
  assign KeyLoaded  = key_loaded_q;
  assign BlockOut   = block_q;
  assign BlockValid = block_valid_q;
  assign ErrFlag    = err_flag_q;
  assign ErrCode    = err_code_q;

endmodule

// File: tb/tb_aes_rx_sequencer.sv
// Scoreboard bench for aes_rx_sequencer with a shortened 100-cycle timeout.
module tb_aes_rx_sequencer;

  localparam int TO_CYCLES = 100;

  localparam int KIND_KEY = 0;
  localparam int KIND_BLK = 1;
  localparam int KIND_ERR = 2;

  typedef struct {
    int           kind;
    logic [127:0] val;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [7:0]   ByteIn = 8'h00;
  logic         ByteReady = 1'b0;
  logic         ReadEn;
  logic [127:0] KeyOut;
  logic         KeyValid;
  logic         KeyLoaded;
  logic [127:0] BlockOut;
  logic         BlockValid;
  logic         BlockReady = 1'b0;
  logic         ErrFlag;
  logic [1:0]   ErrCode;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  logic       bv_prev = 1'b0;
  logic       ef_prev = 1'b0;
  logic [1:0] ec_prev = 2'b00;

  aes_rx_sequencer #(
    .ClkFreq      (100000000),
    .TimeoutCycles(TO_CYCLES),
    .TimeoutBits  (7)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ByteIn    (ByteIn),
    .ByteReady (ByteReady),
    .ReadEn    (ReadEn),
    .KeyOut    (KeyOut),
    .KeyValid  (KeyValid),
    .KeyLoaded (KeyLoaded),
    .BlockOut  (BlockOut),
    .BlockValid(BlockValid),
    .BlockReady(BlockReady),
    .ErrFlag   (ErrFlag),
    .ErrCode   (ErrCode)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [127:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [127:0] val, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got %h expected no event", name, val);
    end else begin
      e = exp_q.pop_front();
      chk({"sb_kind_", name}, 128'(kind), 128'(e.kind));
      chk({"sb_val_", name}, val, e.val);
    end
  endtask

  // Monitor: consumes an expectation each time the DUT presents a result.
  always @(negedge Clk) begin
    if (KeyValid) sb_check(KIND_KEY, KeyOut, "key");
    if (BlockValid && !bv_prev) sb_check(KIND_BLK, BlockOut, "block");
    if (ErrFlag && (!ef_prev || (ErrCode != ec_prev))) sb_check(KIND_ERR, 128'(ErrCode), "err");
    bv_prev = BlockValid;
    ef_prev = ErrFlag;
    ec_prev = ErrCode;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    ByteIn    = b;
    ByteReady = 1'b1;
    @(negedge Clk);
    ByteReady = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ReadEn"}, 128'(ReadEn), 128'd1);
    chk({tag, "_KeyOut"}, KeyOut, 128'd0);
    chk({tag, "_KeyValid"}, 128'(KeyValid), 128'd0);
    chk({tag, "_KeyLoaded"}, 128'(KeyLoaded), 128'd0);
    chk({tag, "_BlockOut"}, BlockOut, 128'd0);
    chk({tag, "_BlockValid"}, 128'(BlockValid), 128'd0);
    chk({tag, "_ErrFlag"}, 128'(ErrFlag), 128'd0);
    chk({tag, "_ErrCode"}, 128'(ErrCode), 128'd0);
  endtask

  logic [7:0]   aes_bytes [16];
  logic [127:0] key0, key1, key2, blk0, blk1;

  initial begin
    aes_bytes = '{8'h32, 8'h43, 8'hF6, 8'hA8, 8'h88, 8'h5A, 8'h30, 8'h8D,
                  8'h31, 8'h31, 8'h98, 8'hA2, 8'hE0, 8'h37, 8'h07, 8'h34};
    key0 = 128'h000102030405060708090A0B0C0D0E0F;
    blk0 = 128'h3243F6A8885A308D313198A2E0370734;
    blk1 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    key1 = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    key2 = 128'h101112131415161718191A1B1C1D1E1F;

    repeat (3) @(negedge Clk);
    check_reset_values("rst");
    Rst = 1'b0;

    // Key load 00..0F.
    push(KIND_KEY, key0);
    send_byte(8'h4B);
    send_payload(8'h00, 15);
    chk("key_readen_loading", 128'(ReadEn), 128'd1);
    send_byte(8'h0F);
    chk("key_valid_pulse", 128'(KeyValid), 128'd1);
    chk("key_loaded", 128'(KeyLoaded), 128'd1);
    @(negedge Clk);
    chk("key_valid_one_cycle", 128'(KeyValid), 128'd0);
    chk("key_readen", 128'(ReadEn), 128'd1);

    // Data block held with BlockReady low for 50 cycles.
    push(KIND_BLK, blk0);
    send_byte(8'h44);
    for (int i = 0; i < 16; i++) send_byte(aes_bytes[i]);
    for (int i = 0; i < 50; i++) begin
      chk("hold_valid", 128'(BlockValid), 128'd1);
      chk("hold_block", BlockOut, blk0);
      chk("hold_readen", 128'(ReadEn), 128'd0);
      @(negedge Clk);
    end
    BlockReady = 1'b1;
    @(negedge Clk);
    BlockReady = 1'b0;
    chk("handshake_valid", 128'(BlockValid), 128'd0);
    chk("handshake_readen", 128'(ReadEn), 128'd1);

    // BlockReady already high: one-cycle BlockValid.
    BlockReady = 1'b1;
    push(KIND_BLK, blk1);
    send_byte(8'h44);
    send_payload(8'hA0, 16);
    chk("fast_valid", 128'(BlockValid), 128'd1);
    chk("fast_readen", 128'(ReadEn), 128'd0);
    @(negedge Clk);
    chk("fast_valid_drop", 128'(BlockValid), 128'd0);
    chk("fast_readen_back", 128'(ReadEn), 128'd1);
    BlockReady = 1'b0;

    // Bad command, then 'K' clears the error.
    push(KIND_ERR, 128'(2'b01));
    send_byte(8'h58);
    chk("badcmd_flag", 128'(ErrFlag), 128'd1);
    chk("badcmd_code", 128'(ErrCode), 128'(2'b01));
    send_byte(8'h4B);
    chk("cmd_clears_flag", 128'(ErrFlag), 128'd0);
    chk("cmd_clears_code", 128'(ErrCode), 128'd0);

    // Timeout after 5 payload bytes, exactly TO_CYCLES clocks after the 5th.
    push(KIND_ERR, 128'(2'b10));
    send_payload(8'h50, 5);
    repeat (TO_CYCLES - 1) @(negedge Clk);
    chk("timeout_not_early", 128'(ErrFlag), 128'd0);
    @(negedge Clk);
    chk("timeout_flag", 128'(ErrFlag), 128'd1);
    chk("timeout_code", 128'(ErrCode), 128'(2'b10));
    chk("timeout_key_kept", KeyOut, key0);
    chk("timeout_readen", 128'(ReadEn), 128'd1);

    // A byte landing on the expiry cycle is accepted instead.
    push(KIND_KEY, key1);
    send_byte(8'h4B);
    repeat (TO_CYCLES - 2) @(negedge Clk);
    send_byte(8'hC0);
    chk("expiry_byte_wins", 128'(ErrFlag), 128'd0);
    send_payload(8'hC1, 15);
    chk("key1_loaded", KeyOut, key1);

    // Reset mid data frame aborts everything.
    send_byte(8'h44);
    send_payload(8'h77, 8);
    Rst = 1'b1;
    @(negedge Clk);
    check_reset_values("midrst");
    Rst = 1'b0;

    // Data frame with no key loaded.
    push(KIND_ERR, 128'(2'b11));
    send_byte(8'h44);
    send_payload(8'h20, 16);
    chk("nokey_code", 128'(ErrCode), 128'(2'b11));
    chk("nokey_valid", 128'(BlockValid), 128'd0);
    chk("nokey_readen", 128'(ReadEn), 128'd1);
    chk("nokey_blockout", BlockOut, 128'd0);

    // Full key frame after reset loads correctly.
    push(KIND_KEY, key2);
    send_byte(8'h4B);
    send_payload(8'h10, 16);
    chk("key2_loaded", 128'(KeyLoaded), 128'd1);
    chk("key2_value", KeyOut, key2);

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_rx_sequencer.md
# aes_rx_sequencer

Receive-side controller between the oversampling serial byte receiver and the AES core. Gates the receiver via `ReadEn`, parses a one-byte command, and assembles 16 payload bytes into a 128-bit key or data block. Presents data blocks to the AES core with a valid/ready handshake. Enforces an inter-byte timeout and reports framing errors.

## Interface
- `ClkFreq`, 100000000: board clock in Hz (Nexys3); informational, used only to derive the default timeout.
- `TimeoutCycles`, 2000000: maximum idle clocks between payload bytes (20 ms at 100 MHz).
- `TimeoutBits`, 21: width of the timeout counter; must satisfy 2^TimeoutBits ≥ TimeoutCycles.

Ports:
- `Clk`  in  1: system clock.
- `Rst`  in  1: reset, synchronous, active-high.
- `ByteIn`  in  8: received byte from the serial receiver.
- `ByteReady`  in  1: one-cycle strobe; `ByteIn` is valid in this cycle.
- `ReadEn`  out  1: enables the serial receiver.
- `KeyOut`  out  128: last loaded key.
- `KeyValid`  out  1: one-cycle pulse when `KeyOut` updates.
- `KeyLoaded`  out  1: level; set once the first key has been loaded.
- `BlockOut`  out  128: assembled data block.
- `BlockValid`  out  1: block available; held until accepted.
- `BlockReady`  in  1: AES core accepts the block.
- `ErrFlag`  out  1: sticky error indication.
- `ErrCode`  out  2: 01 = bad command, 10 = timeout, 11 = data block received with no key loaded.

## Operation
- States:
  - IDLE: wait for a command byte.
  - LOAD: collect 16 payload bytes.
  - HOLD: present a data block to the AES core.
- Commands (IDLE, on `ByteReady`):
  - 8'h4B 'K' → LOAD with target=key.
  - 8'h44 'D' → LOAD with target=data.
  - Any other byte → `ErrFlag`=1, `ErrCode`=01, stay in IDLE.
- A valid command byte clears `ErrFlag`/`ErrCode` and the byte counter.
- Byte assembly in LOAD: the shift register shifts left by 8 and `ByteIn` enters bits [7:0]. The first payload byte therefore ends up in [127:120] (AES byte 0).
- The 4-bit byte counter runs 0..15. On the 16th byte:
  - Key target: `KeyOut` ← assembled value, `KeyValid` pulses, `KeyLoaded`=1, → IDLE.
  - Data target with `KeyLoaded`=1: `BlockOut` ← assembled value, `BlockValid`=1, → HOLD.
  - Data target with `KeyLoaded`=0: block is discarded, `ErrFlag`=1, `ErrCode`=11, → IDLE.
- HOLD: `ReadEn`=0. Bytes arriving in HOLD are dropped by design. When `BlockValid` and `BlockReady` are both high: `BlockValid`=0, → IDLE.
- Timeout in LOAD:
  - The counter clears on every `ByteReady` and increments otherwise.
  - Reaching TimeoutCycles-1 → discard the partial block, `ErrFlag`=1, `ErrCode`=10, → IDLE.
  - `KeyOut`/`BlockOut` are unchanged on timeout.
- The timeout counter is held at 0 outside LOAD.
- `Rst` mid-frame aborts the frame; no partial data is ever output.

## Timing
- Reset values:
  - `ReadEn`=1.
  - `KeyOut`=0, `KeyValid`=0, `KeyLoaded`=0.
  - `BlockOut`=0, `BlockValid`=0.
  - `ErrFlag`=0, `ErrCode`=00.
  - State=IDLE, counters=0.
- All outputs are registered.
- `ReadEn` is 1 in IDLE and LOAD. It is 0 from the cycle after the 16th data byte until the cycle after the handshake.
- Latency: `KeyValid`/`BlockValid` rise on the clock edge following the 16th `ByteReady`.
- Handshake: `BlockReady` is sampled only while `BlockValid`=1. If `BlockReady` is already high when `BlockValid` rises, the transfer completes on the next edge. `BlockValid` is therefore high for exactly one cycle in that case.
- `BlockOut` is stable while `BlockValid`=1.
- Timeout fires exactly TimeoutCycles clocks after the last `ByteReady` or command byte.
- A `ByteReady` in the same cycle as timeout expiry takes priority: the byte is accepted and the counter clears.

## Structure
- Package `aes_uart_pkg`:
  - Command constants CMD_KEY=8'h4B, CMD_DATA=8'h44.
  - Error codes ERR_CMD, ERR_TIMEOUT, ERR_NOKEY.
  - State encoding.
  - BLOCK_BYTES=16.
- Sub-module `byte_timeout`: parameterised counter with clear/enable inputs and an `expired` output.
- Remainder (FSM, shift register, output registers) lives in the top module.

## Test plan
- Reset, then send 'K' + bytes 00..0F → one `KeyValid` pulse; `KeyOut`=128'h000102030405060708090A0B0C0D0E0F; `KeyLoaded`=1; `ReadEn` stays 1.
- After key load, send 'D' + bytes 32 43 F6 A8 88 5A 30 8D 31 31 98 A2 E0 37 07 34 with `BlockReady`=0 for 50 cycles:
  - `BlockValid`=1 and `BlockOut`=128'h3243F6A8885A308D313198A2E0370734, both held.
  - `ReadEn`=0.
  - Raise `BlockReady` → `BlockValid`=0 and `ReadEn`=1 the next cycle.
- From reset, send 'D' + 16 bytes → `ErrCode`=11, `BlockValid` never asserts, state IDLE.
- Send byte 8'h58 in IDLE → `ErrFlag`=1, `ErrCode`=01. A following 'K' clears `ErrFlag` to 0.
- With TimeoutCycles=100, send 'K' + 5 bytes then idle → `ErrCode`=10 exactly 100 cycles after the 5th strobe; `KeyOut` unchanged.
- Assert `Rst` after 'D' + 8 bytes → all outputs at reset values. A subsequent full 'K' frame loads correctly.
